// File: rtl/game_flow_controller.sv
// Space Invaders game sequencer: owns the mode bus and restart pulse, and tracks
// lives, aliens remaining and wave number across title/ready/play/respawn/game-over.
module game_flow_controller #(
  parameter int LIVES_INIT      = 3,
  parameter int ALIEN_COUNT     = 12,
  parameter int READY_FRAMES    = 120,
  parameter int RESPAWN_FRAMES  = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] xCoord,
  input  logic [9:0]  yCoord,
  input  logic        button_start,
  input  logic        spaceship_hit,
  input  logic        alien_killed,
  input  logic        alien_landed,
  output logic [1:0]  mode,
  output logic        restart,
  output logic [1:0]  lives,
  output logic [3:0]  aliens_left,
  output logic [3:0]  wave
);

  localparam logic [1:0] LIVES_L    = 2'(LIVES_INIT);
  localparam logic [3:0] ALIENS_L   = 4'(ALIEN_COUNT);
  localparam logic [7:0] READY_L    = 8'(READY_FRAMES);
  localparam logic [7:0] RESPAWN_L  = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] GAMEOVER_L = 8'(GAMEOVER_FRAMES);

  typedef enum logic [2:0] {
    ST_TITLE, ST_READY, ST_PLAY, ST_RESPAWN, ST_GAME_OVER
  } state_t;

  state_t      state_r;
  logic [7:0]  fcnt_r;
  logic        origin_d_r;
  logic        frame_tick_r;
  logic        start_d_r;
  logic        start_edge_r;
  logic        at_origin_s;
  logic [3:0]  aliens_next_s;
  logic [3:0]  wave_next_s;

  assign at_origin_s = (xCoord == 11'd0) && (yCoord == 10'd0);

  // Alien count after this cycle's kill, and the saturating next wave number.
  always_comb begin
    aliens_next_s = aliens_left;
    wave_next_s   = wave;
    if (alien_killed && (aliens_left != 4'd0)) begin
      aliens_next_s = aliens_left - 4'd1;
    end else begin
      aliens_next_s = aliens_left;
    end
    if (wave == 4'd15) begin
      wave_next_s = 4'd15;
    end else begin
      wave_next_s = wave + 4'd1;
    end
  end

  // Registered rising-edge detectors for frame start and the start button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_d_r   <= 1'b0;
      frame_tick_r <= 1'b0;
      start_d_r    <= 1'b0;
      start_edge_r <= 1'b0;
    end else begin
      origin_d_r   <= at_origin_s;
      frame_tick_r <= at_origin_s & ~origin_d_r;
      start_d_r    <= button_start;
      start_edge_r <= button_start & ~start_d_r;
    end
  end

  // Game phase sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_TITLE;
      mode        <= 2'd0;
      restart     <= 1'b0;
      lives       <= 2'd0;
      aliens_left <= 4'd0;
      wave        <= 4'd0;
      fcnt_r      <= 8'd0;
    end else begin
      restart <= 1'b0;
      case (state_r)
        ST_TITLE: begin
          if (start_edge_r) begin
            state_r     <= ST_READY;
            mode        <= 2'd1;
            lives       <= LIVES_L;
            aliens_left <= ALIENS_L;
            wave        <= 4'd1;
            fcnt_r      <= READY_L;
            restart     <= 1'b1;
          end
        end
        ST_READY: begin
          if (frame_tick_r) begin
            if (fcnt_r == 8'd1) begin
              state_r <= ST_PLAY;
              mode    <= 2'd2;
            end else begin
              fcnt_r <= fcnt_r - 8'd1;
            end
          end
        end
        ST_PLAY: begin
          // Kills always count; a same-cycle transition below may override the count.
          aliens_left <= aliens_next_s;
          if (alien_landed || (spaceship_hit && (lives <= 2'd1))) begin
            state_r <= ST_GAME_OVER;
            mode    <= 2'd3;
            lives   <= 2'd0;
            fcnt_r  <= GAMEOVER_L;
          end else if (spaceship_hit) begin
            state_r <= ST_RESPAWN;
            mode    <= 2'd1;
            lives   <= lives - 2'd1;
            fcnt_r  <= RESPAWN_L;
          end else if (aliens_next_s == 4'd0) begin
            state_r     <= ST_READY;
            mode        <= 2'd1;
            wave        <= wave_next_s;
            aliens_left <= ALIENS_L;
            fcnt_r      <= READY_L;
            restart     <= 1'b1;
          end
        end
        ST_RESPAWN: begin
          if (frame_tick_r) begin
            if (fcnt_r != 8'd1) begin
              fcnt_r <= fcnt_r - 8'd1;
            end else if (aliens_left == 4'd0) begin
              state_r     <= ST_READY;
              mode        <= 2'd1;
              wave        <= wave_next_s;
              aliens_left <= ALIENS_L;
              fcnt_r      <= READY_L;
              restart     <= 1'b1;
            end else begin
              state_r <= ST_PLAY;
              mode    <= 2'd2;
            end
          end
        end
        ST_GAME_OVER: begin
          if (start_edge_r && (fcnt_r == 8'd0)) begin
            state_r <= ST_TITLE;
            mode    <= 2'd0;
            restart <= 1'b1;
          end else if (frame_tick_r && (fcnt_r != 8'd0)) begin
            fcnt_r <= fcnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= ST_TITLE;
          mode    <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: directed scenarios plus random
// stimulus, all compared against a phase-level reference model.
module tb_game_flow_controller;

  localparam int LI = 3;
  localparam int AC = 12;
  localparam int RF = 2;
  localparam int SF = 3;
  localparam int GF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] xCoord;
  logic [9:0]  yCoord;
  logic        button_start, spaceship_hit, alien_killed, alien_landed;
  logic [1:0]  mode;
  logic        restart;
  logic [1:0]  lives;
  logic [3:0]  aliens_left;
  logic [3:0]  wave;

  int n_tests = 0;
  int n_fail  = 0;

  game_flow_controller #(
    .LIVES_INIT(LI), .ALIEN_COUNT(AC), .READY_FRAMES(RF),
    .RESPAWN_FRAMES(SF), .GAMEOVER_FRAMES(GF)
  ) dut (
    .clk(clk), .rst(rst), .xCoord(xCoord), .yCoord(yCoord),
    .button_start(button_start), .spaceship_hit(spaceship_hit),
    .alien_killed(alien_killed), .alien_landed(alien_landed),
    .mode(mode), .restart(restart), .lives(lives),
    .aliens_left(aliens_left), .wave(wave)
  );

  always #5 clk = ~clk;

  // Reference model: game phase (0 title, 1 ready, 2 play, 3 respawn, 4 over),
  // frames remaining, and one-cycle-delayed input edges.
  int m_phase, m_lives, m_aliens, m_wave, m_cnt;
  bit m_restart, m_tick, m_start, m_org_prev, m_btn_prev;
  int mode_of [5] = '{0, 1, 2, 1, 3};

  task automatic model_reset();
    m_phase = 0; m_lives = 0; m_aliens = 0; m_wave = 0; m_cnt = 0;
    m_restart = 0; m_tick = 0; m_start = 0; m_org_prev = 0; m_btn_prev = 0;
  endtask

  task automatic model_new_wave();
    m_phase = 1; m_wave = (m_wave >= 15) ? 15 : m_wave + 1;
    m_aliens = AC; m_cnt = RF; m_restart = 1;
  endtask

  task automatic model_step();
    bit org;
    org = (xCoord == 11'd0) && (yCoord == 10'd0);
    m_restart = 0;
    case (m_phase)
      0: if (m_start) begin
           m_phase = 1; m_lives = LI; m_aliens = AC; m_wave = 1; m_cnt = RF; m_restart = 1;
         end
      1: if (m_tick) begin
           m_cnt--;
           if (m_cnt == 0) m_phase = 2;
         end
      2: begin
           if (alien_killed && m_aliens > 0) m_aliens--;
           if (alien_landed || (spaceship_hit && m_lives == 1)) begin
             m_phase = 4; m_lives = 0; m_cnt = GF;
           end else if (spaceship_hit) begin
             m_phase = 3; m_lives--; m_cnt = SF;
           end else if (m_aliens == 0) begin
             model_new_wave();
           end
         end
      3: if (m_tick) begin
           m_cnt--;
           if (m_cnt == 0) begin
             if (m_aliens == 0) model_new_wave();
             else m_phase = 2;
           end
         end
      default: begin
           if (m_start && m_cnt == 0) begin
             m_phase = 0; m_restart = 1;
           end else if (m_tick && m_cnt > 0) begin
             m_cnt--;
           end
         end
    endcase
    m_tick = org && !m_org_prev;  m_org_prev = org;
    m_start = button_start && !m_btn_prev;  m_btn_prev = button_start;
  endtask

  function automatic logic [12:0] model_vec();
    return {2'(mode_of[m_phase]), m_restart, 2'(m_lives), 4'(m_aliens), 4'(m_wave)};
  endfunction

  task automatic drive(input bit org, input bit btn, input bit hit, input bit kill, input bit land);
    @(negedge clk);
    xCoord = org ? 11'd0 : 11'd100;
    yCoord = org ? 10'd0 : 10'd5;
    button_start = btn; spaceship_hit = hit; alien_killed = kill; alien_landed = land;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    xCoord = 11'd100; yCoord = 10'd5;
    button_start = 1'b0; spaceship_hit = 1'b0; alien_killed = 1'b0; alien_landed = 1'b0;
    model_reset();
    #22;
    n_tests++;
    if ({mode, restart, lives, aliens_left, wave} !== 13'd0) begin
      n_fail++; $display("FAIL reset_state got %h want 0", {mode, restart, lives, aliens_left, wave});
    end
    @(negedge clk); rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({mode, restart, lives, aliens_left, wave} !== model_vec()) begin
      n_fail++; $display("FAIL reset_idle got %h want %h", {mode, restart, lives, aliens_left, wave}, model_vec());
    end
  endtask

  task automatic test_start();
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    n_tests++;
    if ({mode, restart, lives, aliens_left, wave} !== {2'd1, 1'b1, 2'd3, 4'd12, 4'd1}) begin
      n_fail++; $display("FAIL start_load got %h want %h", {mode, restart, lives, aliens_left, wave}, {2'd1, 1'b1, 2'd3, 4'd12, 4'd1});
    end
    drive(0, 1, 0, 0, 0);
    n_tests++;
    if (restart !== 1'b0 || mode !== 2'd1) begin
      n_fail++; $display("FAIL start_held got restart=%b mode=%0d want 0/1", restart, mode);
    end
    drive(0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (mode !== 2'd1) begin
      n_fail++; $display("FAIL ready_first_tick got mode=%0d want 1", mode);
    end
    tick();
    n_tests++;
    if (mode !== 2'd2 || {mode, restart, lives, aliens_left, wave} !== model_vec()) begin
      n_fail++; $display("FAIL ready_to_play got %h want %h", {mode, restart, lives, aliens_left, wave}, model_vec());
    end
  endtask

  task automatic test_respawn();
    bit saw_restart;
    saw_restart = 0;
    drive(0, 0, 1, 0, 0);
    n_tests++;
    if (mode !== 2'd1 || lives !== 2'd2 || restart !== 1'b0) begin
      n_fail++; $display("FAIL hit_respawn got mode=%0d lives=%0d restart=%b want 1/2/0", mode, lives, restart);
    end
    for (int i = 0; i < SF; i++) begin
      drive(1, 0, 0, 0, 0); saw_restart |= restart;
      drive(0, 0, 0, 0, 0); saw_restart |= restart;
      if (i == SF - 2) begin
        n_tests++;
        if (mode !== 2'd1) begin
          n_fail++; $display("FAIL respawn_early got mode=%0d want 1", mode);
        end
      end
    end
    n_tests++;
    if (mode !== 2'd2 || saw_restart !== 1'b0) begin
      n_fail++; $display("FAIL respawn_exit got mode=%0d restart_seen=%b want 2/0", mode, saw_restart);
    end
  endtask

  task automatic test_wave_clear();
    for (int i = 0; i < AC; i++) begin
      drive(0, 0, 0, 1, 0);
      if (i < AC - 1) begin
        n_tests++;
        if (aliens_left !== 4'(AC - 1 - i) || mode !== 2'd2) begin
          n_fail++; $display("FAIL kill_count[%0d] got aliens=%0d mode=%0d want %0d/2", i, aliens_left, mode, AC - 1 - i);
        end
      end
    end
    n_tests++;
    if ({mode, restart, aliens_left, wave} !== {2'd1, 1'b1, 4'd12, 4'd2}) begin
      n_fail++; $display("FAIL wave_clear got %h want %h", {mode, restart, aliens_left, wave}, {2'd1, 1'b1, 4'd12, 4'd2});
    end
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if (restart !== 1'b0) begin
      n_fail++; $display("FAIL wave_restart_len got restart=%b want 0", restart);
    end
    tick(); tick();
  endtask

  task automatic test_hit_and_kill();
    for (int i = 0; i < AC - 1; i++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < SF; i++) tick();
    n_tests++;
    if ({mode, lives, aliens_left} !== {2'd2, 2'd1, 4'd1}) begin
      n_fail++; $display("FAIL setup_last_life got %h want %h", {mode, lives, aliens_left}, {2'd2, 2'd1, 4'd1});
    end
    drive(0, 0, 1, 1, 0);
    n_tests++;
    if ({mode, restart, lives, aliens_left} !== {2'd3, 1'b0, 2'd0, 4'd0}) begin
      n_fail++; $display("FAIL hit_kill_same got %h want %h", {mode, restart, lives, aliens_left}, {2'd3, 1'b0, 2'd0, 4'd0});
    end
  endtask

  task automatic test_game_over();
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0);
    n_tests++;
    if (mode !== 2'd3) begin
      n_fail++; $display("FAIL early_start got mode=%0d want 3", mode);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    // Only GF-1 ticks so far if the held origin counted once: start still refused.
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0);
    n_tests++;
    if (mode !== 2'd3) begin
      n_fail++; $display("FAIL held_origin_ticks got mode=%0d want 3", mode);
    end
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0);
    n_tests++;
    if (mode !== 2'd0 || restart !== 1'b1) begin
      n_fail++; $display("FAIL over_to_title got mode=%0d restart=%b want 0/1", mode, restart);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_landed_and_reset();
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 0, 0, 1);
    n_tests++;
    if (mode !== 2'd3 || lives !== 2'd0) begin
      n_fail++; $display("FAIL landed got mode=%0d lives=%0d want 3/0", mode, lives);
    end
    for (int i = 0; i < GF; i++) tick();
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 1, 0, 0);
    n_tests++;
    if ({mode, restart, lives, aliens_left, wave} !== model_vec() || mode !== 2'd1) begin
      n_fail++; $display("FAIL pre_reset_respawn got %h want %h", {mode, restart, lives, aliens_left, wave}, model_vec());
    end
    @(negedge clk); rst = 1'b1;
    #1;
    n_tests++;
    if (mode !== 2'd0 || lives !== 2'd0 || restart !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got mode=%0d lives=%0d restart=%b want 0/0/0", mode, lives, restart);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    bit btn, org;
    btn = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      org = ($urandom_range(0, 3) == 0);
      drive(org, btn, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
      n_tests++;
      if ({mode, restart, lives, aliens_left, wave} !== model_vec()) begin
        n_fail++; $display("FAIL random[%0d] got %h want %h", i, {mode, restart, lives, aliens_left, wave}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_respawn();
    test_wave_clear();
    test_hit_and_kill();
    test_game_over();
    test_landed_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level game sequencer for the Space Invaders datapath. It owns the `mode[1:0]` bus and the `restart` pulse consumed by the spaceship, alien, flying-saucer and barrier blocks. It tracks lives, aliens remaining and the wave number, and walks the game through title, ready countdown, play, respawn and game-over phases. All phase timing is counted in video frames, derived from the VGA scan coordinates.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives loaded at game start (1..3).
- `ALIEN_COUNT`, 12: aliens per wave (1..15).
- `READY_FRAMES`, 120: frames spent in READY before PLAY (1..255).
- `RESPAWN_FRAMES`, 60: frames spent in RESPAWN after a hit (1..255).
- `GAMEOVER_FRAMES`, 180: minimum frames in GAME_OVER before start is accepted (1..255).

Ports:
- `clk`  in  1  system/pixel clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `xCoord`  in  11  current VGA x.
- `yCoord`  in  10  current VGA y.
- `button_start`  in  1  debounced level.
- `spaceship_hit`  in  1  one-cycle pulse: alien laser struck the spaceship.
- `alien_killed`  in  1  one-cycle pulse: one alien destroyed.
- `alien_landed`  in  1  level: an alien has reached the spaceship row.
- `mode`  out  2  0 = TITLE, 1 = READY/RESPAWN, 2 = PLAY, 3 = GAME_OVER.
- `restart`  out  1  one-cycle pulse; all game objects reinitialise.
- `lives`  out  2  remaining lives.
- `aliens_left`  out  4  aliens remaining in the current wave.
- `wave`  out  4  current wave number, saturating at 15.

## Operation
- `frame_tick`: one-cycle pulse on the first cycle that (`xCoord`,`yCoord`) == (0,0), using a registered edge detect. It stays low while (0,0) persists.
- `start_edge`: rising-edge detect of `button_start`.
- States and the `mode` they drive: TITLE(0), READY(1), PLAY(2), RESPAWN(1), GAME_OVER(3). An 8-bit frame counter `fcnt` is loaded on entry to every timed state and decrements on each `frame_tick`.
- TITLE:
  - `start_edge` → READY.
  - Load `lives`=LIVES_INIT, `aliens_left`=ALIEN_COUNT, `wave`=1, `fcnt`=READY_FRAMES.
  - Pulse `restart`.
- READY: on `frame_tick` with `fcnt`==1 → PLAY.
- PLAY: events are evaluated every cycle, not only on frame ticks. Priority is `alien_landed` > `spaceship_hit` > wave clear.
  - `alien_landed` → GAME_OVER; `lives`←0; `fcnt`=GAMEOVER_FRAMES.
  - `spaceship_hit` with `lives`==1 → GAME_OVER; `lives`←0; `fcnt`=GAMEOVER_FRAMES.
  - `spaceship_hit` with `lives`>1 → RESPAWN; `lives`−1; `fcnt`=RESPAWN_FRAMES.
  - `alien_killed` always decrements `aliens_left`, saturating at 0, even in the same cycle as a hit or landing.
  - If `aliens_left` reaches 0 and no higher-priority event fires → READY. Set `wave`+1 (saturating at 15), reload `aliens_left`=ALIEN_COUNT, set `fcnt`=READY_FRAMES, pulse `restart`.
- RESPAWN: on `frame_tick` with `fcnt`==1:
  - if `aliens_left`==0, perform the wave-clear action above → READY;
  - else → PLAY, with no `restart`. Aliens and barriers keep their state.
- GAME_OVER: `start_edge` with `fcnt`==0 → TITLE and pulse `restart`. `fcnt` stops at 0.
- `spaceship_hit`, `alien_killed` and `alien_landed` are ignored outside PLAY.
- Reset values:
  - `mode`=0, `restart`=0, `lives`=0, `aliens_left`=0, `wave`=0;
  - `fcnt`=0, both edge detectors cleared, state=TITLE.
- Reset mid-game returns to TITLE immediately, asynchronously. `restart` does not pulse on reset.

## Timing
- All outputs are registered. An event sampled at edge n is visible on outputs after edge n. Example: `spaceship_hit` high in cycle n puts `mode`=1 in cycle n+1.
- `restart` is high for exactly one cycle, the same cycle in which the new `mode` first appears.
- `start_edge` and `frame_tick` each add one cycle of latency relative to their raw inputs.
- READY lasts exactly READY_FRAMES frame ticks, including the tick that causes the exit. The same rule applies to RESPAWN.
- A frame tick and an event in the same cycle: the event is handled first, and the counter is loaded (not decremented) in that cycle.
- A held `button_start` produces only one transition. A new press requires the button to go low first.

## Test plan
- Reset, then one `start_edge` with READY_FRAMES=2 → `restart` pulses once; `mode`=1, `lives`=3, `aliens_left`=12, `wave`=1. After the second `frame_tick`, `mode`=2.
- In PLAY with `lives`=3, pulse `spaceship_hit` → `mode`=1, `lives`=2. After RESPAWN_FRAMES ticks, `mode`=2 with no `restart` pulse.
- Twelve `alien_killed` pulses in PLAY → `aliens_left` goes 12..0. The cycle after the last pulse: `mode`=1, `wave`=2, `aliens_left`=12, `restart` high for 1 cycle.
- `spaceship_hit` and `alien_killed` in the same cycle with `lives`=1, `aliens_left`=1 → `mode`=3, `lives`=0, `aliens_left`=0, no `restart`.
- In GAME_OVER, press start before GAMEOVER_FRAMES ticks → ignored. Release, let `fcnt` reach 0, press again → `mode`=0 and `restart` pulses. Holding (0,0) for 4 cycles yields one `frame_tick`.
- Assert `rst` during RESPAWN → `mode`=0, `lives`=0 immediately. `alien_landed` in PLAY → `mode`=3 on the next cycle.
